// File: rtl/sc_io_pkg.sv
// sc_io_pkg: IO window base, word addresses and status bit layout for sc_io_responder
package sc_io_pkg;
  localparam logic [31:0] IO_BASE     = 32'h0000_0080;
  localparam logic [31:0] IO_WIN_MASK = 32'h0000_007F;
  localparam logic [7:0]  ADDR_OUT0   = 8'h80;
  localparam logic [7:0]  ADDR_OUT1   = 8'h84;
  localparam logic [7:0]  ADDR_OUT2   = 8'h88;
  localparam logic [7:0]  ADDR_IN0    = 8'hC0;
  localparam logic [7:0]  ADDR_IN1    = 8'hC4;
  localparam logic [7:0]  ADDR_IN2    = 8'hC8;
  localparam logic [7:0]  ADDR_STATUS = 8'hCC;
  localparam int          STAT_CHG0   = 0;
  localparam int          STAT_CHG1   = 1;
  localparam int          STAT_CHG2   = 2;
endpackage

// File: rtl/sc_io_debounce.sv
// sc_io_debounce: two-flop synchronizer, optional stability counter (SC_IO_DEBOUNCE_EN), debounced word and change pulse
//   in: clock, resetn (async active-low), in_word[31:0]; out: deb[31:0], change (high on the edge deb updates)
module sc_io_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] in_word,
  output logic [31:0] deb,
  output logic        change
);
  logic [31:0] sync1, sync2, deb_next;
`ifdef SC_IO_DEBOUNCE_EN
  logic [7:0] cnt, cnt_next;
  logic hold, fire;
  // restart the count while settled or while sync2 is itself still moving
  assign hold     = (sync2 == deb) || (sync1 != sync2);
  assign fire     = !hold && (cnt == 8'(DEB_CYCLES - 1));
  assign deb_next = fire ? sync2 : deb;
  assign cnt_next = (hold || fire) ? 8'd0 : cnt + 8'd1;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= cnt_next;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^8'(DEB_CYCLES);
  assign deb_next = sync2;
`endif
  assign change = deb_next != deb;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
    end else begin
      sync1 <= in_word;
      sync2 <= sync1;
      deb   <= deb_next;
    end
endmodule

// File: rtl/sc_io_responder.sv
// sc_io_responder: memory-mapped IO block (3 out ports, 3 debounced in ports, read-to-clear change status, irq)
//   in: clock, resetn (async active-low), addr, wdata, wmem, rmem, in_port0..2
//   out: out_port0..2, io_sel, io_rdata, irq; macro SC_IO_DEBOUNCE_EN enables the DEB_CYCLES stability filter
module sc_io_responder
  import sc_io_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  input  logic        rmem,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        irq
);
  logic [7:0]  off;
  logic [2:0]  flags, change;
  logic [31:0] in_w [3];
  logic [31:0] deb [3];
  logic [31:0] status;
  logic        wr, clr;
  assign in_w[0] = in_port0;
  assign in_w[1] = in_port1;
  assign in_w[2] = in_port2;
  for (genvar i = 0; i < 3; i++) begin : g_port
    sc_io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock  (clock),
      .resetn (resetn),
      .in_word(in_w[i]),
      .deb    (deb[i]),
      .change (change[i])
    );
  end
  assign io_sel = (addr & ~IO_WIN_MASK) == IO_BASE;
  assign off    = {addr[7:2], 2'b00};
  assign wr     = wmem && io_sel;
  assign clr    = rmem && io_sel && (off == ADDR_STATUS);
  always_comb begin
    status            = '0;
    status[STAT_CHG0] = flags[0];
    status[STAT_CHG1] = flags[1];
    status[STAT_CHG2] = flags[2];
    io_rdata = !io_sel              ? 32'd0     :
               off == ADDR_OUT0     ? out_port0 :
               off == ADDR_OUT1     ? out_port1 :
               off == ADDR_OUT2     ? out_port2 :
               off == ADDR_IN0      ? deb[0]    :
               off == ADDR_IN1      ? deb[1]    :
               off == ADDR_IN2      ? deb[2]    :
               off == ADDR_STATUS   ? status    : 32'd0;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
      flags     <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr && off == ADDR_OUT0) out_port0 <= wdata;
      if (wr && off == ADDR_OUT1) out_port1 <= wdata;
      if (wr && off == ADDR_OUT2) out_port2 <= wdata;
      flags <= (clr ? 3'b000 : flags) | change;
      irq   <= |flags;
    end
endmodule

// File: tb/tb_sc_io_responder.sv
// tb_sc_io_responder: scoreboard bench for sc_io_responder (expected values queued at stimulus, compared at sampling)
module tb_sc_io_responder;
  localparam int DEB = 4;
`ifdef SC_IO_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
  localparam logic [31:0] GLITCH_FLAG = 32'd0;
`else
  localparam int LAT = 3;
  localparam logic [31:0] GLITCH_FLAG = 32'd1;
`endif
  logic clock = 1'b0;
  logic resetn;
  logic [31:0] addr, wdata, in0, in1, in2;
  logic wmem, rmem;
  logic [31:0] out0, out1, out2, io_rdata;
  logic io_sel, irq;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string nm_q[$];

  sc_io_responder #(.DEB_CYCLES(DEB)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .wmem(wmem), .rmem(rmem),
    .in_port0(in0), .in_port1(in1), .in_port2(in2),
    .out_port0(out0), .out_port1(out1), .out_port2(out2),
    .io_sel(io_sel), .io_rdata(io_rdata), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    addr = a; wdata = d; wmem = w; rmem = r;
  endtask

  task automatic push_exp(input string name, input logic [31:0] v);
    nm_q.push_back(name);
    exp_q.push_back(v);
  endtask

  task automatic test_reset;
    logic [31:0] e, o;
    string s;
    resetn = 1'b0; in0 = 32'hFFFF_FFFF; in1 = '0; in2 = '0;
    drive(32'h80, 32'h1234_0000, 1'b1, 1'b0);
    push_exp("rst_out0", 0); push_exp("rst_out1", 0); push_exp("rst_out2", 0);
    push_exp("rst_irq", 0); push_exp("rst_rd_c0", 0); push_exp("rst_sel_c0", 1);
    repeat (3) @(posedge clock);
    #1 drive(32'hC0, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(out0); obs_q.push_back(out1); obs_q.push_back(out2);
    obs_q.push_back({31'd0, irq}); obs_q.push_back(io_rdata); obs_q.push_back({31'd0, io_sel});
    in0 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    drive(32'hCC, 0, 1'b0, 1'b0);
    push_exp("post_rst_status", 0);
    repeat (LAT + 2) @(posedge clock);
    #1 obs_q.push_back(io_rdata);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_write;
    logic [31:0] e, o;
    string s;
    @(negedge clock) drive(32'h84, 32'h1234_5678, 1'b1, 1'b0);
    push_exp("wr_rd_before_edge", 0);
    #1 obs_q.push_back(io_rdata);
    push_exp("wr_out1", 32'h1234_5678); push_exp("wr_out0_kept", 0); push_exp("wr_out2_kept", 0);
    @(posedge clock);
    #1 obs_q.push_back(out1); obs_q.push_back(out0); obs_q.push_back(out2);
    @(negedge clock) drive(32'h84, 0, 1'b0, 1'b0);
    push_exp("rd_84", 32'h1234_5678);
    #1 obs_q.push_back(io_rdata);
    @(negedge clock) drive(32'h80, 32'hAAAA_0000, 1'b1, 1'b0);
    @(negedge clock) drive(32'h88, 32'h0000_BBBB, 1'b1, 1'b0);
    @(negedge clock) drive(32'h88, 0, 1'b0, 1'b0);
    push_exp("rd_88", 32'h0000_BBBB); push_exp("out0_val", 32'hAAAA_0000);
    #1 obs_q.push_back(io_rdata); obs_q.push_back(out0);
    @(negedge clock) drive(32'h87, 0, 1'b0, 1'b0);
    push_exp("rd_87_low_bits_ignored", 32'h1234_5678);
    #1 obs_q.push_back(io_rdata);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_debounce;
    logic [31:0] e, o;
    string s;
    @(negedge clock) in2 = 32'h0000_00A5;
    drive(32'hCC, 0, 1'b0, 1'b0);
    for (int k = 1; k <= LAT + 2; k++) begin
      push_exp($sformatf("deb_status_e%0d", k), (k >= LAT) ? 32'h4 : 32'h0);
      push_exp($sformatf("deb_irq_e%0d", k), (k >= LAT + 1) ? 32'h1 : 32'h0);
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clock);
      #1 obs_q.push_back(io_rdata); obs_q.push_back({31'd0, irq});
    end
    @(negedge clock) drive(32'hC8, 0, 1'b0, 1'b0);
    push_exp("rd_c8", 32'hA5);
    #1 obs_q.push_back(io_rdata);
    @(negedge clock) drive(32'hCC, 0, 1'b0, 1'b1);
    push_exp("clr_read", 32'h4); push_exp("after_clr", 0); push_exp("irq_lag", 1); push_exp("irq_cleared", 0);
    #1 obs_q.push_back(io_rdata);
    @(posedge clock);
    #1 drive(32'hCC, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(io_rdata); obs_q.push_back({31'd0, irq});
    @(posedge clock);
    #1 obs_q.push_back({31'd0, irq});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_glitch;
    logic [31:0] e, o;
    string s;
    @(negedge clock) in0 = 32'h1;
    drive(32'hCC, 0, 1'b0, 1'b0);
    push_exp("glitch_flag0", GLITCH_FLAG); push_exp("glitch_rd_c0", 0);
    repeat (2) @(posedge clock);
    @(negedge clock) in0 = 32'h0;
    repeat (10) @(posedge clock);
    #1 obs_q.push_back(io_rdata & 32'h1);
    drive(32'hC0, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(io_rdata);
    @(negedge clock) drive(32'hCC, 0, 1'b0, 1'b1);
    @(posedge clock);
    #1 drive(32'hCC, 0, 1'b0, 1'b0);
    @(posedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_clear_race;
    logic [31:0] e, o;
    string s;
    @(negedge clock) in0 = 32'h1;
    repeat (LAT + 2) @(posedge clock);
    @(negedge clock) in1 = 32'h7;
    push_exp("race_clr_read", 32'h1); push_exp("race_next_read", 32'h2); push_exp("race_irq", 1);
    push_exp("race_final", 0);
    repeat (LAT - 1) @(posedge clock);
    @(negedge clock) drive(32'hCC, 0, 1'b0, 1'b1);
    #1 obs_q.push_back(io_rdata);
    @(posedge clock);
    #1 drive(32'hCC, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(io_rdata); obs_q.push_back({31'd0, irq});
    @(negedge clock) drive(32'hCC, 0, 1'b0, 1'b1);
    @(posedge clock);
    #1 drive(32'hCC, 0, 1'b0, 1'b0);
    @(posedge clock);
    #1 obs_q.push_back(io_rdata);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] e, o;
    string s;
    @(negedge clock) drive(32'h90, 0, 1'b0, 1'b0);
    push_exp("rd_90", 0);
    #1 obs_q.push_back(io_rdata);
    drive(32'hC0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    push_exp("ro_rd_c0", 32'h1); push_exp("ro_out0", 32'hAAAA_0000);
    push_exp("ro_out1", 32'h1234_5678); push_exp("ro_out2", 32'h0000_BBBB);
    @(posedge clock);
    #1 drive(32'hC0, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(io_rdata); obs_q.push_back(out0); obs_q.push_back(out1); obs_q.push_back(out2);
    @(negedge clock) drive(32'h100, 32'h5555_5555, 1'b1, 1'b0);
    push_exp("sel_100", 0); push_exp("rd_100", 0); push_exp("sel_8000_0084", 0);
    push_exp("out0_after_100", 32'hAAAA_0000);
    #1 obs_q.push_back({31'd0, io_sel}); obs_q.push_back(io_rdata);
    @(posedge clock);
    #1 drive(32'h8000_0084, 32'h6666_6666, 1'b1, 1'b0);
    #1 obs_q.push_back({31'd0, io_sel});
    @(posedge clock);
    #1 drive(32'h0, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(out0);
    push_exp("out1_after_far", 32'h1234_5678);
    obs_q.push_back(out1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] e, o;
    string s;
    @(negedge clock) in2 = 32'h0000_005A;
    drive(32'hC8, 0, 1'b0, 1'b0);
    push_exp("arst_out1", 0); push_exp("arst_rd_c8", 0); push_exp("arst_out0", 0);
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1 obs_q.push_back(out1); obs_q.push_back(io_rdata); obs_q.push_back(out0);
    @(negedge clock) resetn = 1'b1;
    drive(32'hCC, 0, 1'b0, 1'b0);
    for (int k = 1; k <= LAT + 1; k++)
      push_exp($sformatf("reacq_status_e%0d", k), (k >= LAT) ? 32'h7 : 32'h0);
    push_exp("reacq_rd_c8", 32'h5A);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clock);
      #1 obs_q.push_back(io_rdata);
    end
    drive(32'hC8, 0, 1'b0, 1'b0);
    #1 obs_q.push_back(io_rdata);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = nm_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h expected %h", s, o, e); end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_debounce;
    test_glitch;
    test_clear_race;
    test_unmapped;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
